// File: rtl/turn_pkg.sv
// Shared constants for the turn sequencer: FSM state encodings and default board size.
package turn_pkg;

  // 3-bit state encoding; the value 7 is unused and recovers to StInitial.
  localparam logic [2:0] StInitial = 3'd0;
  localparam logic [2:0] StChoice  = 3'd1;
  localparam logic [2:0] StPutWait = 3'd2;
  localparam logic [2:0] StWrite   = 3'd3;
  localparam logic [2:0] StCheck   = 3'd4;
  localparam logic [2:0] StChange  = 3'd5;
  localparam logic [2:0] StOver    = 3'd6;

  // 15x15 board.
  localparam int unsigned BoardCells = 225;

endpackage

// File: rtl/turn_sequencer_if.sv
// Control bundle between the turn sequencer and its front end / board / win-check datapath.
interface turn_sequencer_if #(
  parameter int unsigned PLAYER_W = 1,
  parameter int unsigned MOVE_W   = 8
);
  logic                put;
  logic                move_legal;
  logic                check_done;
  logic                check_win;
  logic                restart;
  logic [PLAYER_W-1:0] current_player;
  logic                change_able_read;
  logic                write_en;
  logic                check_req;
  logic                change_turn;
  logic                illegal_pulse;
  logic                timeout_pulse;
  logic                game_over;
  logic                draw;
  logic [PLAYER_W-1:0] winner;
  logic [MOVE_W-1:0]   move_count;

  // Environment side: front end, board and win checker.
  modport master (
    output put, move_legal, check_done, check_win, restart,
    input  current_player, change_able_read, write_en, check_req, change_turn,
    input  illegal_pulse, timeout_pulse, game_over, draw, winner, move_count
  );

  // Sequencer side.
  modport slave (
    input  put, move_legal, check_done, check_win, restart,
    output current_player, change_able_read, write_en, check_req, change_turn,
    output illegal_pulse, timeout_pulse, game_over, draw, winner, move_count
  );
endinterface

// File: rtl/turn_timer.sv
// Per-turn cycle counter with synchronous clear, count enable and expiry flag.
module turn_timer #(
  parameter int unsigned TURN_TIMEOUT = 0,
  parameter int unsigned TIMER_W      = 32
) (
  input  logic clock,
  input  logic resetn,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  logic [TIMER_W-1:0] count_q, count_d;

  // Clear wins over enable; otherwise count up while enabled.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Expiry flags the last allowed cycle so the FSM can leave on that same cycle.
  generate
    if (TURN_TIMEOUT == 0) begin : g_no_timeout
      assign expire_o = 1'b0;
    end else begin : g_timeout
      assign expire_o = (count_q == TIMER_W'(TURN_TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/turn_sequencer.sv
// N-player turn FSM: legality-gated board write, win-check handshake, per-turn timeout,
// move counting with draw detection and a terminal game-over state with restart.
module turn_sequencer
  import turn_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS  = 2,
  parameter int unsigned PLAYER_W     = $clog2(NUM_PLAYERS),
  parameter int unsigned MAX_MOVES    = BoardCells,
  parameter int unsigned MOVE_W       = $clog2(MAX_MOVES + 1),
  parameter int unsigned TURN_TIMEOUT = 0,
  parameter int unsigned TIMER_W      = 32
) (
  input logic             clock,
  input logic             resetn,
  turn_sequencer_if.slave seq_io
);

  logic [2:0]          state_q, state_d;
  logic [PLAYER_W-1:0] player_q, player_d;
  logic [PLAYER_W-1:0] winner_q, winner_d;
  logic [MOVE_W-1:0]   count_q, count_d;
  logic                draw_q, draw_d;
  logic                legal_q, legal_d;
  logic                timer_clear;
  logic                timer_en;
  logic                timer_expire;

  // Timer freezes on the cycle put is seen and throughout PUT_WAIT; an illegal
  // release resumes the same turn budget rather than restarting it.
  assign timer_clear = (state_q == StInitial) || (state_q == StChange);
  assign timer_en    = (state_q == StChoice) && !seq_io.put;

  turn_timer #(
    .TURN_TIMEOUT (TURN_TIMEOUT),
    .TIMER_W      (TIMER_W)
  ) u_timer (
    .clock    (clock),
    .resetn   (resetn),
    .clear_i  (timer_clear),
    .enable_i (timer_en),
    .expire_o (timer_expire)
  );

  // Next-state and datapath-register update.
  always_comb begin
    state_d  = state_q;
    player_d = player_q;
    winner_d = winner_q;
    count_d  = count_q;
    draw_d   = draw_q;
    legal_d  = legal_q;
    case (state_q)
      StInitial: begin
        legal_d = 1'b0;
        state_d = StChoice;
      end
      StChoice: begin
        legal_d = seq_io.move_legal;
        if (seq_io.put) begin
          state_d = StPutWait;
        end else if (timer_expire) begin
          state_d = StChange;
        end
      end
      StPutWait: begin
        if (!seq_io.put) begin
          state_d = legal_q ? StWrite : StChoice;
        end
      end
      StWrite: begin
        if (count_q != MOVE_W'(MAX_MOVES)) begin
          count_d = count_q + 1'b1;
        end
        state_d = StCheck;
      end
      StCheck: begin
        if (seq_io.check_done) begin
          // A win on the final move beats the draw.
          if (seq_io.check_win) begin
            state_d  = StOver;
            winner_d = player_q;
            draw_d   = 1'b0;
          end else if (count_q == MOVE_W'(MAX_MOVES)) begin
            state_d = StOver;
            draw_d  = 1'b1;
          end else begin
            state_d = StChange;
          end
        end
      end
      StChange: begin
        player_d = (player_q == PLAYER_W'(NUM_PLAYERS - 1)) ? '0 : player_q + 1'b1;
        state_d  = StChoice;
      end
      StOver: begin
        if (seq_io.restart) begin
          state_d  = StInitial;
          player_d = '0;
          count_d  = '0;
          winner_d = '0;
          draw_d   = 1'b0;
        end
      end
      default: state_d = StInitial;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StInitial;
      player_q <= '0;
      winner_q <= '0;
      count_q  <= '0;
      draw_q   <= 1'b0;
      legal_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      player_q <= player_d;
      winner_q <= winner_d;
      count_q  <= count_d;
      draw_q   <= draw_d;
      legal_q  <= legal_d;
    end
  end

  // Moore strobes from the state register; the two event pulses also qualify on inputs.
  always_comb begin
    seq_io.change_able_read = (state_q == StChoice);
    seq_io.write_en         = (state_q == StWrite);
    seq_io.check_req        = (state_q == StCheck);
    seq_io.change_turn      = (state_q == StChange);
    seq_io.game_over        = (state_q == StOver);
    seq_io.illegal_pulse    = (state_q == StPutWait) && !seq_io.put && !legal_q;
    seq_io.timeout_pulse    = (state_q == StChoice) && !seq_io.put && timer_expire;
    seq_io.current_player   = player_q;
    seq_io.winner           = winner_q;
    seq_io.draw             = draw_q;
    seq_io.move_count       = count_q;
  end

endmodule
